// File: rtl/uofdm_pkg.sv
// uofdm_pkg: shared FSM state type, parameter defaults and subframe length helper for the U-OFDM flip block.
// Optional feature macro: UOFDM_CP_EN (cyclic prefix ahead of each subframe).
package uofdm_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, POS_OUT, NEG_OUT} state_e;
  localparam int N_DEF = 128;
  localparam int DW_DEF = 16;
  localparam int CP_LEN_DEF = 16;
  function automatic int sub_len(input int n, input int cp);
`ifdef UOFDM_CP_EN
    return n + cp;
`else
    return n;
`endif
  endfunction
endpackage

// File: rtl/uofdm_buf.sv
// uofdm_buf: simple dual-port N x DW frame RAM, registered 1-cycle read held while re_i is low.
// Ports: clk; write we_i/wa_i/wd_i; read re_i/ra_i -> rd_o one cycle later.
module uofdm_buf import uofdm_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic          re_i,
  input  logic [AW-1:0] ra_i,
  output logic [DW-1:0] rd_o
);
  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_q <= mem_q[ra_i];
  end
  assign rd_o = rd_q;
endmodule

// File: rtl/uofdm_flip.sv
// uofdm_flip: captures a bipolar IFFT frame and replays it as positive then negated-negative unipolar subframes.
// Ports: clk, reset (async active-low); src_* frame input with src_ready; dac_* output stream with dac_ready
// backpressure; err_frame one-cycle pulse on a malformed frame.
// Optional feature macro: UOFDM_CP_EN prefixes each subframe with CP_LEN samples from addresses N-CP_LEN..N-1.
module uofdm_flip import uofdm_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CP_LEN = CP_LEN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          src_valid,
  input  logic          src_sop,
  input  logic          src_eop,
  input  logic [DW-1:0] src_real,
  output logic          src_ready,
  output logic [DW-1:0] dac_data,
  output logic          dac_valid,
  output logic          dac_sop,
  output logic          dac_eop,
  output logic          dac_pol,
  input  logic          dac_ready,
  output logic          err_frame
);
  localparam int AW = $clog2(N);
  localparam int L = sub_len(N, CP_LEN);
  localparam int CW = $clog2(L);
  state_e state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, wa, ra;
  logic [CW-1:0] idx_q, idx_d;
  logic v_q, v_d, sop_q, sop_d, eop_q, eop_d, pol_q, pol_d, done_q, done_d, err_q, err_d;
  logic acc, adv, last, we, re;
  logic [DW-1:0] rd, neg_raw;
  uofdm_buf #(.N(N), .DW(DW)) u_buf (
    .clk  (clk),
    .we_i (we),
    .wa_i (wa),
    .wd_i (src_real),
    .re_i (re),
    .ra_i (ra),
    .rd_o (rd)
  );
  // reset input gates src_ready so it reads 0 while held in reset and 1 right after release
  assign src_ready = reset && (state_q == IDLE || state_q == CAPTURE);
  assign acc = src_valid && src_ready;
  // output register may be refilled when empty or when its current sample is taken
  assign adv = !v_q || dac_ready;
  assign last = idx_q == CW'(L - 1);
`ifdef UOFDM_CP_EN
  assign ra = idx_q < CW'(CP_LEN) ? AW'(idx_q + CW'(N - CP_LEN)) : AW'(idx_q - CW'(CP_LEN));
`else
  assign ra = AW'(idx_q);
`endif
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    idx_d = idx_q;
    v_d = v_q;
    sop_d = sop_q;
    eop_d = eop_q;
    pol_d = pol_q;
    done_d = done_q;
    err_d = 1'b0;
    we = 1'b0;
    re = 1'b0;
    wa = src_sop ? '0 : wr_q;
    if (acc && (src_sop || state_q == CAPTURE)) begin
      we = 1'b1;
      wr_d = wa + 1'b1;
      idx_d = '0;
      state_d = src_eop && wa == AW'(N - 1) ? POS_OUT : src_eop || wa == AW'(N - 1) ? IDLE : CAPTURE;
      err_d = (src_eop || wa == AW'(N - 1)) && !(src_eop && wa == AW'(N - 1));
    end
    if ((state_q == POS_OUT || state_q == NEG_OUT) && adv) begin
      v_d = !done_q;
      sop_d = !done_q && idx_q == '0;
      eop_d = !done_q && last;
      re = !done_q;
      if (!done_q) begin
        pol_d = state_q == NEG_OUT;
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last && state_q == POS_OUT ? NEG_OUT : state_q;
        done_d = last && state_q == NEG_OUT;
      end
    end
    if (state_q == NEG_OUT && done_q && v_q && eop_q && dac_ready) begin
      state_d = IDLE;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      idx_q <= '0;
      v_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      pol_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      v_q <= v_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      pol_q <= pol_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // negating the most negative code wraps back to itself; its set sign bit selects the saturated maximum
  assign neg_raw = -rd;
  assign dac_data = !v_q ? '0 : !pol_q ? (rd[DW-1] ? '0 : rd) :
                    !rd[DW-1] ? '0 : neg_raw[DW-1] ? {1'b0, {(DW-1){1'b1}}} : neg_raw;
  assign dac_valid = v_q;
  assign dac_sop = sop_q;
  assign dac_eop = eop_q;
  assign dac_pol = pol_q;
  assign err_frame = err_q;
endmodule

// File: tb/tb_uofdm_flip.sv
// tb_uofdm_flip: directed/randomized self-checking bench for uofdm_flip against a frame-level reference model.
module tb_uofdm_flip;
  localparam int N = 128;
  localparam int DW = 16;
  localparam int CP = 16;
`ifdef UOFDM_CP_EN
  localparam int C = CP;
`else
  localparam int C = 0;
`endif
  localparam int L = N + C;
  logic clk = 1'b0, reset = 1'b0, src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0, dac_ready = 1'b1;
  logic [DW-1:0] src_real = '0;
  logic src_ready, dac_valid, dac_sop, dac_eop, dac_pol, err_frame;
  logic [DW-1:0] dac_data;
  int ncmp = 0, nbad = 0, cyc = 0, err_cnt = 0, val_cnt = 0, stall_viol = 0, t_done = 0;
  int frame [N];
  logic [18:0] q [$];
  int qc [$];
  bit rnd_ready = 1'b0, prev_stall = 1'b0;
  logic [19:0] prev = '0;

  uofdm_flip #(.N(N), .DW(DW), .CP_LEN(CP)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_real  (src_real),
    .src_ready (src_ready),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .dac_sop   (dac_sop),
    .dac_eop   (dac_eop),
    .dac_pol   (dac_pol),
    .dac_ready (dac_ready),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    dac_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (err_frame) err_cnt++;
    if (dac_valid) val_cnt++;
    if (dac_valid && dac_ready) begin
      q.push_back({dac_pol, dac_sop, dac_eop, dac_data});
      qc.push_back(cyc);
    end
    if (reset && prev_stall && prev != {dac_valid, dac_pol, dac_sop, dac_eop, dac_data}) stall_viol++;
    prev = {dac_valid, dac_pol, dac_sop, dac_eop, dac_data};
    prev_stall = reset && dac_valid && !dac_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: subframe s, position j; CP positions read the frame tail, then the whole frame in order
  function automatic logic [18:0] exp_at(input int k);
    int s, j, a, x, v;
    s = k / L;
    j = k % L;
    a = j < C ? N - C + j : j - C;
    x = frame[a];
    if (s == 0) v = x > 0 ? x : 0;
    else v = x < 0 ? (-x > 32767 ? 32767 : -x) : 0;
    return {s[0], j == 0, j == L - 1, 16'(v)};
  endfunction

  task automatic check_run(input string tag);
    chk({tag, "_len"}, 64'(q.size()), 64'(2 * L));
    for (int k = 0; k < 2 * L && k < q.size(); k++) chk($sformatf("%s_%0d", tag, k), 64'(q[k]), 64'(exp_at(k)));
  endtask

  task automatic send(input int n, input int eop_at);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_sop = i == 0;
      src_eop = i == eop_at;
      src_real = 16'(frame[i]);
      @(posedge clk);
      #1;
    end
    src_valid = 1'b0;
    src_sop = 1'b0;
    src_eop = 1'b0;
    t_done = cyc;
  endtask

  task automatic wait_out(input int need);
    int b;
    b = 0;
    while (q.size() < need && b < 5000) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("out_timeout", 64'(b < 5000), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  initial begin
    int b, e0, v0, n0, d;
    logic [18:0] q1 [$];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(dac_valid), 64'd0);
    chk("rst_data", 64'(dac_data), 64'd0);
    chk("rst_sop", 64'(dac_sop), 64'd0);
    chk("rst_eop", 64'(dac_eop), 64'd0);
    chk("rst_pol", 64'(dac_pol), 64'd0);
    chk("rst_err", 64'(err_frame), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("rel_ready", 64'(src_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) frame[i] = i - 64;
    q.delete();
    qc.delete();
    send(N, N - 1);
    wait_out(2 * L);
    check_run("ramp");
    chk("ramp_pos65", 64'(q[C + 65][15:0]), 64'd1);
    chk("ramp_pos64", 64'(q[C + 64][15:0]), 64'd0);
    chk("ramp_neg0", 64'(q[L + C][15:0]), 64'd64);
    chk("ramp_latency", 64'(qc[0] - t_done <= 2), 64'd1);
    chk("ramp_gapfree", 64'(qc[2 * L - 1] - qc[0]), 64'(2 * L - 1));
    chk("ramp_idle", 64'(src_ready), 64'd1);
    rand_frame();
    frame[7] = -32768;
    frame[9] = 0;
    q.delete();
    send(N, N - 1);
    wait_out(2 * L);
    check_run("rnd_r1");
    chk("min_pos", 64'(q[C + 7][15:0]), 64'd0);
    chk("min_neg", 64'(q[L + C + 7][15:0]), 64'd32767);
    q1 = q;
    rnd_ready = 1'b1;
    stall_viol = 0;
    q.delete();
    send(N, N - 1);
    wait_out(2 * L);
    rnd_ready = 1'b0;
    check_run("rnd_stall");
    d = 0;
    for (int k = 0; k < q.size() && k < q1.size(); k++) if (q[k] !== q1[k]) d++;
    chk("stall_same_seq", 64'(d), 64'd0);
    chk("stall_stable", 64'(stall_viol), 64'd0);
    rand_frame();
    e0 = err_cnt;
    v0 = val_cnt;
    send(101, 100);
    repeat (10) @(posedge clk);
    #1;
    chk("early_eop_err", 64'(err_cnt - e0), 64'd1);
    chk("early_eop_novalid", 64'(val_cnt - v0), 64'd0);
    chk("early_eop_ready", 64'(src_ready), 64'd1);
    e0 = err_cnt;
    send(N, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("no_eop_err", 64'(err_cnt - e0), 64'd1);
    chk("no_eop_novalid", 64'(val_cnt - v0), 64'd0);
    q.delete();
    send(N, N - 1);
    wait_out(2 * L);
    check_run("after_err");
    e0 = err_cnt;
    send(50, -1);
    rand_frame();
    q.delete();
    send(N, N - 1);
    wait_out(2 * L);
    check_run("restart");
    chk("restart_noerr", 64'(err_cnt - e0), 64'd0);
    q.delete();
    send(N, N - 1);
    b = 0;
    while (q.size() < 40 && b < 1000) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("mid_timeout", 64'(b < 1000), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_valid", 64'(dac_valid), 64'd0);
    chk("mid_data", 64'(dac_data), 64'd0);
    chk("mid_sop", 64'(dac_sop), 64'd0);
    chk("mid_eop", 64'(dac_eop), 64'd0);
    chk("mid_pol", 64'(dac_pol), 64'd0);
    chk("mid_ready", 64'(src_ready), 64'd0);
    n0 = q.size();
    v0 = val_cnt;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(src_ready), 64'd1);
    repeat (300) @(posedge clk);
    #1;
    chk("mid_no_valid", 64'(val_cnt - v0), 64'd0);
    chk("mid_no_xfer", 64'(q.size()), 64'(n0));
    rand_frame();
    q.delete();
    send(N, N - 1);
    wait_out(2 * L);
    check_run("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/uofdm_flip.md
UOFDM_FLIP -- requirements
Module: uofdm_flip

Interface
REQ-001 SHALL have parameter N, default 128, meaning samples per IFFT frame (power of two).
REQ-002 SHALL have parameter DW, default 16, meaning sample width, two's complement in, unsigned out.
REQ-003 SHALL have parameter CP_LEN, default 16, meaning cyclic-prefix length (used only with UOFDM_CP_EN; CP_LEN < N).
REQ-004 SHALL have ports: clk  in  1  single clock; every register on its rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: src_valid, src_sop, src_eop  in  1 each  IFFT output frame handshake and markers.
REQ-007 SHALL have ports: src_real  in  DW  signed real time-domain sample.
REQ-008 SHALL have ports: src_ready  out  1  block can accept a sample this cycle.
REQ-009 SHALL have ports: dac_data  out  DW  unipolar sample; dac_valid, dac_sop, dac_eop, dac_pol  out  1 each (dac_pol 0 = positive subframe, 1 = negative subframe).
REQ-010 SHALL have ports: dac_ready  in  1  downstream accepts sample; err_frame  out  1  one-cycle pulse on a malformed input frame.

Function
REQ-011 SHALL implement FSM IDLE, CAPTURE, POS_OUT, NEG_OUT; src_ready = 1 only in IDLE and CAPTURE.
REQ-012 SHALL accept a sample when src_valid && src_ready; in IDLE only an accepted sample with src_sop=1 starts a frame (write address 0, go CAPTURE); other IDLE samples are dropped silently.
REQ-013 SHALL write accepted samples at consecutive addresses 0..N-1 into the frame buffer.
REQ-014 SHALL accept sample N-1 with src_eop=1 as frame complete -> POS_OUT; the frame is then read out.
REQ-015 SHALL treat src_eop before address N-1, or src_eop=0 at address N-1, as malformed: pulse err_frame for one cycle, discard the frame, return to IDLE.
REQ-016 SHALL restart the capture at address 0 with no err_frame pulse when src_sop=1 arrives mid-CAPTURE.
REQ-017 SHALL emit in POS_OUT N samples, addresses 0..N-1: dac_data = x if x > 0, else 0.
REQ-018 SHALL then emit in NEG_OUT the same N addresses: dac_data = -x if x < 0, else 0; x = most negative code yields 2^(DW-1)-1 (saturate).
REQ-019 SHALL assert dac_sop on the first and dac_eop on the last sample of each subframe, and hold dac_pol constant across a subframe.
REQ-020 SHALL hold dac_data, dac_valid, dac_sop, dac_eop and dac_pol stable while dac_valid && !dac_ready, and advance only on dac_valid && dac_ready.
REQ-021 SHALL produce the first dac_valid no more than 2 cycles after completion of the frame capture; with dac_ready held 1, output SHALL be gap-free for the whole positive and negative subframe pair.
REQ-022 SHALL return to IDLE after the NEG_OUT eop is accepted.

Reset
REQ-023 SHALL, on reset low, asynchronously clear the FSM to IDLE and drive dac_data=0, dac_valid=0, dac_sop=0, dac_eop=0, dac_pol=0, err_frame=0, src_ready=0, with all address counters cleared.
REQ-024 SHALL assert src_ready in the first cycle after reset release; buffer contents are not reset.
REQ-025 SHALL abandon any frame in progress when reset asserts mid-operation; no partial subframe completes after reset release.

Configuration
REQ-026 SHALL, with UOFDM_CP_EN defined, prefix each subframe with CP_LEN samples read from addresses N-CP_LEN..N-1 (same sign rule), giving N+CP_LEN samples per subframe; dac_sop marks the first CP sample.
REQ-027 SHALL, without UOFDM_CP_EN, emit exactly N samples per subframe and contain no CP logic.

Structure
REQ-028 SHALL place the FSM state encoding type and the defaults for N, DW and CP_LEN in the shared package uofdm_pkg.
REQ-029 SHALL use one sub-module, uofdm_buf: simple dual-port N x DW RAM with a registered 1-cycle read, single clock.

Verification
REQ-030 SHALL verify: reset, then a ramp frame x[i]=i-64 (N=128) with sop/eop correct, dac_ready=1 -> positive subframe gives 0 for i<=64 and i-64 for i>64; negative subframe gives 64-i for i<64 and 0 otherwise; sop/eop/pol correct; 256 contiguous valids.
REQ-031 SHALL verify: sample x=-32768 (DW=16) -> NEG_OUT value 32767, POS_OUT value 0.
REQ-032 SHALL verify: src_eop at sample 100 -> err_frame pulses once, no dac_valid, src_ready stays 1, next good frame outputs normally.
REQ-033 SHALL verify: dac_ready toggled at random 50% -> output sequence identical to the dac_ready=1 run, with outputs stable during stalls.
REQ-034 SHALL verify: reset asserted at sample 40 of POS_OUT -> outputs cleared immediately, IDLE with src_ready=1 after release, no partial subframe completes.
REQ-035 SHALL verify: with UOFDM_CP_EN and CP_LEN=16 -> each subframe 144 samples, with the first 16 equal to processed samples 112..127.
